// File: rtl/col2img_writeback.sv
// col2img_writeback: scatters S2P x S2P GEMM result tiles into column-major result memory.
// Optional RELU_EN: negative elements are written as zero; timing and addresses are unchanged.
`ifndef S2P_SIZE
`define S2P_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 16
`endif

module col2img_writeback #(
  parameter int S2P = `S2P_SIZE,
  parameter int DW  = `DATA_WIDTH,
  parameter int AW  = `ADDR_SIZE
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic [AW-1:0]                out_pixels,
  input  logic [`KERNEL_NUMS_SIZE-1:0] kernel_nums,
  input  logic [AW-1:0]                base_addr,
  input  logic                         tile_valid,
  input  logic [S2P*S2P*DW-1:0]        i_matrix_result,
  output logic                         tile_ready,
  output logic [AW-1:0]                o_result_addr,
  output logic [DW-1:0]                o_result_data,
  output logic                         o_wr_en,
  output logic                         o_done
);

  localparam int KW = `KERNEL_NUMS_SIZE;
  localparam int MW = AW + KW;
  localparam int TW = S2P * S2P * DW;
  localparam int RW = (S2P > 1) ? $clog2(S2P) : 1;
  localparam int CW = $clog2(S2P + 1);

  typedef enum logic [1:0] {IDLE, WAIT_TILE, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] op_q, op_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [KW-1:0] kn_q, kn_d;
  logic [KW-1:0] col_base_q, col_base_d;
  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] c_q, c_d;
  logic [TW-1:0] tile_q, tile_d;
  logic          tile_ready_q, tile_ready_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [AW-1:0] rem_rows;
  logic [KW-1:0] rem_cols;
  logic [CW-1:0] vr, vc;
  logic          last_row_tile, last_col_tile;
  logic          last_r, last_elem, hs;
  logic [RW-1:0] nr, nc;

  function automatic logic [DW-1:0] elem(
    input logic [TW-1:0] t,
    input logic [RW-1:0] r,
    input logic [RW-1:0] c
  );
    logic [DW-1:0] e;
    e = t[(int'(r) * S2P + int'(c)) * DW +: DW];
`ifdef RELU_EN
    if (e[DW-1]) e = '0;
`endif
    return e;
  endfunction

  function automatic logic [AW-1:0] addr_of(
    input logic [AW-1:0] base,
    input logic [AW-1:0] op,
    input logic [KW-1:0] cb,
    input logic [RW-1:0] c,
    input logic [AW-1:0] rb,
    input logic [RW-1:0] r
  );
    logic [MW-1:0] col;
    logic [MW-1:0] sum;
    col = MW'(cb) + MW'(c);
    sum = MW'(base) + col * MW'(op) + MW'(rb) + MW'(r);
    return AW'(sum);
  endfunction

  always_comb begin
    rem_rows      = op_q - row_base_q;
    rem_cols      = kn_q - col_base_q;
    last_row_tile = rem_rows <= AW'(S2P);
    last_col_tile = rem_cols <= KW'(S2P);
    vr            = last_row_tile ? CW'(rem_rows) : CW'(S2P);
    vc            = last_col_tile ? CW'(rem_cols) : CW'(S2P);
    last_r        = CW'(r_q) == (vr - CW'(1));
    last_elem     = last_r && (CW'(c_q) == (vc - CW'(1)));
    hs            = (state_q == WAIT_TILE) && tile_ready_q && tile_valid;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    base_d       = base_q;
    kn_d         = kn_q;
    row_base_d   = row_base_q;
    col_base_d   = col_base_q;
    r_d          = r_q;
    c_d          = c_q;
    tile_d       = tile_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tile_ready_d = 1'b0;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;
    nr           = r_q;
    nc           = c_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          op_d       = out_pixels;
          kn_d       = kernel_nums;
          base_d     = base_addr;
          row_base_d = '0;
          col_base_d = '0;
          r_d        = '0;
          c_d        = '0;
          if (out_pixels == '0 || kernel_nums == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_TILE;
          end
        end
      end
      WAIT_TILE: begin
        if (hs) begin
          // element (0,0) goes out straight from the bus so the first write lands next cycle
          tile_d  = i_matrix_result;
          r_d     = '0;
          c_d     = '0;
          state_d = WRITE;
          wr_en_d = 1'b1;
          addr_d  = addr_of(base_q, op_q, col_base_q, RW'(0),
                            row_base_q, RW'(0));
          data_d  = elem(i_matrix_result, RW'(0), RW'(0));
        end else begin
          tile_ready_d = 1'b1;
        end
      end
      WRITE: begin
        if (last_elem) begin
          if (last_row_tile && last_col_tile) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_TILE;
            if (last_col_tile) begin
              col_base_d = '0;
              row_base_d = row_base_q + AW'(S2P);
            end else begin
              col_base_d = col_base_q + KW'(S2P);
            end
          end
        end else begin
          if (last_r) begin
            nr = '0;
            nc = c_q + RW'(1);
          end else begin
            nr = r_q + RW'(1);
          end
          r_d     = nr;
          c_d     = nc;
          wr_en_d = 1'b1;
          addr_d  = addr_of(base_q, op_q, col_base_q, nc, row_base_q, nr);
          data_d  = elem(tile_q, nr, nc);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= IDLE;
      op_q         <= '0;
      base_q       <= '0;
      kn_q         <= '0;
      row_base_q   <= '0;
      col_base_q   <= '0;
      r_q          <= '0;
      c_q          <= '0;
      tile_q       <= '0;
      tile_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      base_q       <= base_d;
      kn_q         <= kn_d;
      row_base_q   <= row_base_d;
      col_base_q   <= col_base_d;
      r_q          <= r_d;
      c_q          <= c_d;
      tile_q       <= tile_d;
      tile_ready_q <= tile_ready_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign tile_ready    = tile_ready_q;
  assign o_wr_en       = wr_en_q;
  assign o_done        = done_q;
  assign o_result_addr = addr_q;
  assign o_result_data = data_q;

endmodule

// File: tb/tb_col2img_writeback.sv
// Scoreboard bench for col2img_writeback: driver queues expected writes per
// accepted tile, a negedge monitor pops and compares every write and done pulse.
module tb_col2img_writeback;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         enable = 1'b0;
  logic [15:0]  out_pixels = '0;
  logic [15:0]  kernel_nums = '0;
  logic [15:0]  base_addr = '0;
  logic         tile_valid = 1'b0;
  logic [127:0] i_matrix_result = '0;
  logic         tile_ready;
  logic [15:0]  o_result_addr;
  logic [7:0]   o_result_data;
  logic         o_wr_en;
  logic         o_done;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  logic [15:0] last_addr = '0;
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;
  logic exp_prev_wr = 1'b0;

  col2img_writeback dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .out_pixels     (out_pixels),
    .kernel_nums    (kernel_nums),
    .base_addr      (base_addr),
    .tile_valid     (tile_valid),
    .i_matrix_result(i_matrix_result),
    .tile_ready     (tile_ready),
    .o_result_addr  (o_result_addr),
    .o_result_data  (o_result_data),
    .o_wr_en        (o_wr_en),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_wr_en) begin
      wr_cnt++;
      checks++;
      if (tile_ready) begin
        errors++;
        $display("FAIL ready_in_write addr=%h", o_result_addr);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%h/%h required=none",
                 o_result_addr, o_result_data);
      end else begin
        e = exp_q.pop_front();
        if (o_result_addr !== e.a || o_result_data !== e.d) begin
          errors++;
          $display("FAIL write actual=%h/%h required=%h/%h",
                   o_result_addr, o_result_data, e.a, e.d);
        end
      end
      last_addr = o_result_addr;
    end
    if (o_done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() != 0 || prev_wr !== exp_prev_wr || prev_done) begin
        errors++;
        $display("FAIL done pending=%0d prev_wr=%0b required_prev_wr=%0b prev_done=%0b",
                 exp_q.size(), prev_wr, exp_prev_wr, prev_done);
      end
    end
    prev_wr = o_wr_en;
    prev_done = o_done;
  end

  function automatic logic [127:0] tile_word(input int t, input logic [7:0] pat);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(t * 16 + i) ^ pat;
    return w;
  endfunction

  task automatic push_tile(input int t, input int op, input int kn,
                           input logic [15:0] base, input logic [7:0] pat,
                           output int sz);
    int rt, ct, vr, vc, ctn;
    exp_t e;
    logic [7:0] d;
    ctn = (kn + 3) / 4;
    rt = t / ctn;
    ct = t % ctn;
    vr = op - rt * 4;
    if (vr > 4) vr = 4;
    vc = kn - ct * 4;
    if (vc > 4) vc = 4;
    for (int c = 0; c < vc; c++) begin
      for (int r = 0; r < vr; r++) begin
        e.a = 16'(int'(base) + (ct * 4 + c) * op + rt * 4 + r);
        d = 8'(t * 16 + r * 4 + c) ^ pat;
`ifdef RELU_EN
        if (d[7]) d = 8'h00;
`endif
        e.d = d;
        exp_q.push_back(e);
      end
    end
    sz = vr * vc;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, int'(tile_ready), 0);
    chk({tag, "_wr_en"}, int'(o_wr_en), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_addr"}, int'(o_result_addr), 0);
    chk({tag, "_data"}, int'(o_result_data), 0);
  endtask

  task automatic run_job(input int op, input int kn, input logic [15:0] base,
                         input logic [7:0] pat, input int abort_at);
    int ntile, t, wr0, dn0, exp_wr, ready_cyc, prev_hs, prev_sz, sz;
    bit after_hs, fin;
    ntile = ((op + 3) / 4) * ((kn + 3) / 4);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    exp_wr = 0;
    ready_cyc = 0;
    prev_hs = -1;
    prev_sz = 0;
    after_hs = 0;
    fin = 0;
    t = 0;
    exp_prev_wr = (ntile > 0);
    @(negedge clk);
    enable = 1'b1;
    out_pixels = 16'(op);
    kernel_nums = 16'(kn);
    base_addr = base;
    @(negedge clk);
    enable = 1'b0;
    out_pixels = 16'd3;
    kernel_nums = 16'd2;
    base_addr = 16'h0000;
    tile_valid = 1'b1;
    i_matrix_result = tile_word(0, pat);
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      #1;
      if (after_hs) begin
        chk("first_wr_latency", int'(o_wr_en), 1);
        after_hs = 0;
      end
      if (tile_ready) ready_cyc++;
      if (abort_at > 0 && wr_cnt - wr0 == abort_at) begin
        rstn = 1'b1;
        #1;
        chk("abort_wr_en", int'(o_wr_en), 0);
        exp_q.delete();
        tile_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_writes", wr_cnt - wr0, abort_at);
        chk_idle_outputs("abort_rst");
        rstn = 1'b0;
        return;
      end
      if (done_cnt != dn0) begin
        fin = 1;
      end else if (tile_ready && tile_valid) begin
        if (prev_hs >= 0) chk("tile_period", cyc - prev_hs, prev_sz + 2);
        prev_hs = cyc;
        push_tile(t, op, kn, base, pat, sz);
        prev_sz = sz;
        exp_wr += sz;
        t++;
        @(posedge clk);
        #1;
        if (t < ntile) i_matrix_result = tile_word(t, pat);
        else tile_valid = 1'b0;
        after_hs = 1;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL timeout op=%0d kn=%0d", op, kn);
    end
    tile_valid = 1'b0;
    chk("tiles_accepted", t, ntile);
    chk("write_count", wr_cnt - wr0, exp_wr);
    chk("done_count", done_cnt - dn0, 1);
    if (ntile == 0) chk("ready_never", ready_cyc, 0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rstn = 1'b0;

    run_job(4, 4, 16'h0100, 8'h00, 0);
    chk("last_addr_4x4", int'(last_addr), 'h010F);
    chk("writes_4x4", wr_cnt, 16);

    run_job(9, 5, 16'h0400, 8'h00, 0);
    chk("last_addr_9x5", int'(last_addr), 'h042C);

    run_job(4, 0, 16'h0800, 8'h00, 0);
    run_job(0, 3, 16'h0900, 8'h00, 0);

    run_job(4, 4, 16'h0200, 8'h00, 7);
    run_job(4, 4, 16'h0200, 8'h30, 0);
    chk("restart_last_addr", int'(last_addr), 'h020F);

    run_job(2, 2, 16'hFFFE, 8'h00, 0);
    chk("wrap_last_addr", int'(last_addr), 'h0001);

    run_job(1, 1, 16'h0050, 8'hF6, 0);
`ifdef RELU_EN
    chk("relu_data", int'(o_result_data), 'h00);
`else
    chk("raw_data", int'(o_result_data), 'hF6);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/col2img_writeback.md
COL2IMG_WRITEBACK -- requirements
Module: col2img_writeback

Interface
REQ-001 Parameter S2P, default `S2P_SIZE (4): tile edge; tile holds S2P*S2P elements.
REQ-002 Parameter DW, default `DATA_WIDTH (8): element width, two's complement.
REQ-003 Parameter AW, default `ADDR_SIZE (16): result memory address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-high reset (high = reset).
REQ-006 enable  in  1  start pulse; sampled only in IDLE.
REQ-007 out_pixels  in  AW  output pixels per kernel (out_feature_size squared); GEMM result rows.
REQ-008 kernel_nums  in  `KERNEL_NUMS_SIZE  kernel count; GEMM result columns.
REQ-009 base_addr  in  AW  result memory base address.
REQ-010 tile_valid  in  1  GEMM result tile available.
REQ-011 i_matrix_result  in  S2P*S2P*DW  tile, element (r,c) at bits [(r*S2P+c)*DW +: DW].
REQ-012 tile_ready  out  1  tile accepted when tile_valid && tile_ready.
REQ-013 o_result_addr  out  AW  write address.
REQ-014 o_result_data  out  DW  write data.
REQ-015 o_wr_en  out  1  write strobe; addr/data valid only while high.
REQ-016 o_done  out  1  one-cycle pulse after the last write of the last tile.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_TILE, WRITE, DONE.
REQ-018 On enable in IDLE, the block SHALL latch out_pixels, kernel_nums and base_addr, clear the tile counters, and enter WAIT_TILE; enable in other states SHALL be ignored.
REQ-019 If the latched out_pixels or kernel_nums is 0, the block SHALL go IDLE->DONE, issue no writes, and pulse o_done.
REQ-020 tile_ready SHALL be high only in WAIT_TILE; a handshake SHALL register the tile and enter WRITE.
REQ-021 Tile order SHALL be row_tile outer (0..ceil(out_pixels/S2P)-1) and col_tile inner (0..ceil(kernel_nums/S2P)-1).
REQ-022 valid_rows SHALL be min(S2P, out_pixels-row_tile*S2P), and valid_cols SHALL be min(S2P, kernel_nums-col_tile*S2P).
REQ-023 Padded elements SHALL produce no write and no idle cycle.
REQ-024 In WRITE, exactly one element SHALL be written per cycle, with c outer and r inner, so that consecutive writes hit consecutive addresses.
REQ-025 The write address SHALL be base_addr + (col_tile*S2P+c)*out_pixels + row_tile*S2P + r, truncated modulo 2^AW.
REQ-026 The first o_wr_en SHALL occur the cycle after the handshake.
REQ-027 A tile SHALL take exactly valid_rows*valid_cols cycles in WRITE.
REQ-028 After the last element of a tile, the FSM SHALL return to WAIT_TILE, or go to DONE if it was the final tile.
REQ-029 DONE SHALL assert o_done for one cycle, then return to IDLE.
REQ-030 tile_valid outside WAIT_TILE SHALL be ignored, and i_matrix_result SHALL be sampled only at the handshake.
REQ-031 The internal multiply SHALL use width AW + `KERNEL_NUMS_SIZE before truncation.

Reset
REQ-032 While rstn is high, the state SHALL be IDLE, the counters 0, and tile_ready, o_wr_en, o_done, o_result_addr and o_result_data all 0.
REQ-033 Reset asserted mid-tile SHALL abort immediately with no further writes; after release the block SHALL wait for a new enable.

Configuration
REQ-034 With RELU_EN defined, each element SHALL be replaced by 0 when its sign bit is set before it drives o_result_data.
REQ-035 Without RELU_EN, o_result_data SHALL equal the raw tile element.
REQ-036 Timing and addresses SHALL be identical with and without RELU_EN.

Verification
REQ-037 S2P=4, out_pixels=4, kernel_nums=4, base=0x100, one tile with element (r,c)=r*4+c -> 16 writes at 0x100..0x10F with data 0,4,8,12,1,5,...,15, then o_done one cycle later.
REQ-038 out_pixels=9, kernel_nums=5 -> 6 tiles accepted; last tile gives 1 write at base+4*9+8; 45 writes total, no duplicate addresses.
REQ-039 tile_valid held high continuously -> tile_ready low throughout WRITE; a full 4x4 tile gives an 18-cycle period per tile (handshake cycle + 16 writes + return to WAIT_TILE).
REQ-040 kernel_nums=0 with enable -> no o_wr_en, o_done pulses, tile_ready never rises.
REQ-041 rstn pulsed after the 7th write of a tile -> o_wr_en low in the same cycle; a new run restarts at base_addr.
REQ-042 Element 8'hF6: with RELU_EN -> data 0x00; without RELU_EN -> data 0xF6.
